// File: rtl/cpm_sc_driver_pkg.sv
// Shared types and sizes for the CPM scan-chain driver and its edge decoder.
package cpm_pkg;

  localparam int N_SEL  = 4;   // width of the CPM select register S[1:N_SEL]
  localparam int N_TDC  = 16;  // width of the CPM thermometer edge word
  localparam int EDGE_W = 5;   // enough bits to hold an edge position 0..N_TDC

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    TAIL,
    LATCH
  } sc_state_t;

endpackage

// File: rtl/cpm_sc_driver_if.sv
// Request handshake plus the serial scan waveform towards the CPM receiver.
// The master side issues requests; the slave side is the scan driver.
interface cpm_sc_driver_if;
  import cpm_pkg::*;

  logic [1:N_SEL] cfg_s;
  logic           cfg_valid;
  logic           cfg_ready;
  logic           done;
  logic           sc_din;
  logic           sc_clk;
  logic           sc_len;

  modport master (
    output cfg_s, cfg_valid,
    input  cfg_ready, done, sc_din, sc_clk, sc_len
  );

  modport slave (
    input  cfg_s, cfg_valid,
    output cfg_ready, done, sc_din, sc_clk, sc_len
  );

endinterface

// File: rtl/cpm_sc_driver_therm_decode.sv
// Thermometer edge decoder for the CPM edge word: counts leading ones from
// bit 1 and flags any 1 that follows the first 0 (a bubble). Outputs are
// registered, one cycle after cpm_out. Only built when CPM_THERM_DECODE_EN
// is defined.
`ifdef CPM_THERM_DECODE_EN
module cpm_therm_decode
  import cpm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [1:N_TDC]    cpm_out,
  output logic [EDGE_W-1:0] edge_pos,
  output logic              bubble
);

  logic [EDGE_W-1:0] edge_next;
  logic              bubble_next;
  logic              seen_zero;

  // Scan from bit 1: ones before the first zero count toward the edge,
  // ones after it mark a bubble.
  always_comb begin
    edge_next   = '0;
    bubble_next = 1'b0;
    seen_zero   = 1'b0;
    for (int i = 1; i <= N_TDC; i++) begin
      if (!cpm_out[i]) begin
        seen_zero = 1'b1;
      end else if (seen_zero) begin
        bubble_next = 1'b1;
      end else begin
        edge_next = edge_next + EDGE_W'(1);
      end
    end
  end

  // Register the decoded edge every cycle, independent of the scan FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_pos <= '0;
      bubble   <= 1'b0;
    end else begin
      edge_pos <= edge_next;
      bubble   <= bubble_next;
    end
  end

endmodule
`endif

// File: rtl/cpm_sc_driver.sv
// CPM scan-chain driver: shifts a 4-bit select value out on sc_din/sc_clk,
// S[4] first, then pulses sc_len to latch it. Each phase lasts CLK_DIV clocks.
// Optional thermometer decoder enabled by the CPM_THERM_DECODE_EN macro.
module cpm_sc_driver
  import cpm_pkg::*;
#(
  parameter logic [7:0] CLK_DIV = 8'd4  // legal 1..255
)
(
  input  logic              clk,
  input  logic              rst,
  cpm_sc_driver_if.slave    bus
`ifdef CPM_THERM_DECODE_EN
  ,
  input  logic [1:N_TDC]    cpm_out,
  output logic [EDGE_W-1:0] edge_pos,
  output logic              bubble
`endif
);

  sc_state_t      state_reg, state_next;
  logic [7:0]     phase_reg, phase_next;
  logic [1:0]     bit_reg, bit_next;
  logic [1:N_SEL] shift_reg, shift_next;
  logic           phase_end;
  logic           accept;

  logic cfg_ready_reg, cfg_ready_next;
  logic done_reg, done_next;
  logic sc_din_reg, sc_din_next;
  logic sc_clk_reg, sc_clk_next;
  logic sc_len_reg, sc_len_next;

  assign phase_end = (phase_reg == CLK_DIV - 8'd1);
  assign accept    = bus.cfg_valid && (state_reg == IDLE);

  // Next state, counters and shift data; outputs are decoded from the next
  // state so that the registered outputs line up with the state they describe.
  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    bit_next   = bit_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = SHIFT_LO;
          shift_next = bus.cfg_s;
          bit_next   = 2'd0;
        end
      end
      SHIFT_LO: if (phase_end) state_next = SHIFT_HI;
      SHIFT_HI: begin
        if (phase_end) begin
          if (bit_reg == 2'd3) begin
            state_next = TAIL;
          end else begin
            // Move the next-lower select bit into the output slot S[N_SEL].
            state_next = SHIFT_LO;
            bit_next   = bit_reg + 2'd1;
            shift_next = {1'b0, shift_reg[1:N_SEL-1]};
          end
        end
      end
      TAIL:    if (phase_end) state_next = LATCH;
      LATCH:   if (phase_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase

    phase_next = ((state_next != state_reg) || (state_reg == IDLE)) ? 8'd0
                                                                     : phase_reg + 8'd1;

    sc_din_next    = ((state_next == SHIFT_LO) || (state_next == SHIFT_HI)) ?
                     shift_next[N_SEL] : 1'b0;
    sc_clk_next    = (state_next == SHIFT_HI);
    sc_len_next    = (state_next == LATCH);
    cfg_ready_next = (state_next == IDLE);
    done_next      = (state_reg == LATCH) && (state_next == IDLE);
  end

  // State, counters and registered outputs; reset abandons any transfer
  // without a latch pulse so the CPM keeps its previous select value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      phase_reg     <= 8'd0;
      bit_reg       <= 2'd0;
      shift_reg     <= '0;
      cfg_ready_reg <= 1'b1;
      done_reg      <= 1'b0;
      sc_din_reg    <= 1'b0;
      sc_clk_reg    <= 1'b0;
      sc_len_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      phase_reg     <= phase_next;
      bit_reg       <= bit_next;
      shift_reg     <= shift_next;
      cfg_ready_reg <= cfg_ready_next;
      done_reg      <= done_next;
      sc_din_reg    <= sc_din_next;
      sc_clk_reg    <= sc_clk_next;
      sc_len_reg    <= sc_len_next;
    end
  end

  assign bus.cfg_ready = cfg_ready_reg;
  assign bus.done      = done_reg;
  assign bus.sc_din    = sc_din_reg;
  assign bus.sc_clk    = sc_clk_reg;
  assign bus.sc_len    = sc_len_reg;

`ifdef CPM_THERM_DECODE_EN
  cpm_therm_decode u_decode (
    .clk      (clk),
    .rst      (rst),
    .cpm_out  (cpm_out),
    .edge_pos (edge_pos),
    .bubble   (bubble)
  );
`endif

endmodule

// File: tb/tb_cpm_sc_driver.sv
// Testbench for cpm_sc_driver: one instance with CLK_DIV=2 and one with
// CLK_DIV=1, a behavioural scan receiver, and (under CPM_THERM_DECODE_EN)
// decoder checks.
module tb_cpm_sc_driver;
  import cpm_pkg::*;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           sel1 = 1'b0;       // 1: drive/observe the CLK_DIV=1 instance
  logic           req_valid = 1'b0;
  logic [1:N_SEL] req_s = '0;
  int             n_checks = 0;
  int             n_pass = 0;

  // Behavioural receiver: shifts sc_din in at stage 1 on sc_clk rising edges,
  // copies the chain to rx_s while sc_len is high.
  logic [1:N_SEL] rx_shift = '0;
  logic [1:N_SEL] rx_s = '0;
  logic           prev_clk = 1'b0;

  always #5 clk = ~clk;

  cpm_sc_driver_if bus2();
  cpm_sc_driver_if bus1();

  assign bus2.cfg_s     = req_s;
  assign bus1.cfg_s     = req_s;
  assign bus2.cfg_valid = req_valid & ~sel1;
  assign bus1.cfg_valid = req_valid & sel1;

`ifdef CPM_THERM_DECODE_EN
  logic [1:N_TDC]    cpm_out = '0;
  logic [EDGE_W-1:0] edge_pos2, edge_pos1;
  logic              bubble2, bubble1;
`endif

  cpm_sc_driver #(.CLK_DIV(8'd2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
`ifdef CPM_THERM_DECODE_EN
    ,
    .cpm_out  (cpm_out),
    .edge_pos (edge_pos2),
    .bubble   (bubble2)
`endif
  );

  cpm_sc_driver #(.CLK_DIV(8'd1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
`ifdef CPM_THERM_DECODE_EN
    ,
    .cpm_out  (cpm_out),
    .edge_pos (edge_pos1),
    .bubble   (bubble1)
`endif
  );

  // Observed vector {ready, done, din, sck, len} of the selected instance.
  logic [4:0] obs;
  logic [4:0] obs2, obs1;
  assign obs2 = {bus2.cfg_ready, bus2.done, bus2.sc_din, bus2.sc_clk, bus2.sc_len};
  assign obs1 = {bus1.cfg_ready, bus1.done, bus1.sc_din, bus1.sc_clk, bus1.sc_len};
  assign obs  = sel1 ? obs1 : obs2;

  // Expected {ready, done, din, sck, len} in cycle c after an accept at edge 0.
  function automatic logic [4:0] expect_vec(input int d, input logic [1:N_SEL] s, input int c);
    logic rdy, dn, din, sck, len;
    int k;
    rdy = 1'b0; dn = 1'b0; din = 1'b0; sck = 1'b0; len = 1'b0;
    if (c <= 8 * d) begin
      k   = (c - 1) / (2 * d);
      din = s[N_SEL - k];
      sck = (((c - 1) % (2 * d)) >= d);
    end else if (c > 10 * d) begin
      rdy = 1'b1;
      dn  = 1'b1;
    end else if (c > 9 * d) begin
      len = 1'b1;
    end
    return {rdy, dn, din, sck, len};
  endfunction

  // Advance one cycle, sample after the edge and feed the receiver model.
  task automatic tick();
    @(posedge clk);
    #1;
    if (obs[0]) begin
      n_checks++;
      if (obs[1] !== prev_clk)
        $display("FAIL sc_clk_edge_during_len: sc_clk %b, required %b", obs[1], prev_clk);
      else
        n_pass++;
      rx_s = rx_shift;
    end else if (obs[1] && !prev_clk) begin
      rx_shift = {obs[2], rx_shift[1:N_SEL-1]};
    end
    prev_clk = obs[1];
  endtask

  // One full transfer of s; optionally keep valid high and present next_s
  // (or scrambled values) while busy, so the next call starts back-to-back.
  task automatic xfer(input int d, input logic [1:N_SEL] s, input bit keep,
                      input bit scramble, input logic [1:N_SEL] next_s, input string tag);
    logic [4:0] exp;
    n_checks++;
    if (obs[4] !== 1'b1)
      $display("FAIL %s ready_before_request: got %b, required 1", tag, obs[4]);
    else
      n_pass++;
    req_s     = s;
    req_valid = 1'b1;
    for (int c = 1; c <= 10 * d + 1; c++) begin
      tick();
      if (!keep) req_valid = 1'b0;
      else req_s = (scramble && c <= 10 * d) ? N_SEL'($urandom_range(0, 15)) : next_s;
      exp = expect_vec(d, s, c);
      n_checks++;
      if (obs !== exp)
        $display("FAIL %s cycle %0d {rdy,done,din,sck,len}: got %b, required %b", tag, c, obs, exp);
      else
        n_pass++;
    end
    n_checks++;
    if (rx_s !== s)
      $display("FAIL %s receiver_s: got %b, required %b", tag, rx_s, s);
    else
      n_pass++;
  endtask

  task automatic expect_idle(input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) begin
      tick();
      n_checks++;
      if (obs !== 5'b10000)
        $display("FAIL %s idle_cycle %0d: got %b, required 10000", tag, i, obs);
      else
        n_pass++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if (obs2 !== 5'b10000) $display("FAIL reset_div2: got %b, required 10000", obs2);
    else n_pass++;
    n_checks++;
    if (obs1 !== 5'b10000) $display("FAIL reset_div1: got %b, required 10000", obs1);
    else n_pass++;
`ifdef CPM_THERM_DECODE_EN
    n_checks++;
    if ({edge_pos2, bubble2, edge_pos1, bubble1} !== '0)
      $display("FAIL reset_decode: got %0d/%b %0d/%b, required 0/0 0/0",
               edge_pos2, bubble2, edge_pos1, bubble1);
    else n_pass++;
`endif
    rst = 1'b0;
    expect_idle(2, "post_reset");
  endtask

  task automatic test_basic();
    sel1 = 1'b0;
    xfer(2, 4'b1010, 1'b0, 1'b0, 4'b0000, "basic_1010");
    expect_idle(2, "basic_after");
  endtask

  task automatic test_back_to_back();
    xfer(2, 4'b0001, 1'b1, 1'b0, 4'b1111, "b2b_first");
    xfer(2, 4'b1111, 1'b0, 1'b0, 4'b0000, "b2b_second");
    expect_idle(2, "b2b_after");
  endtask

  task automatic test_reset_mid();
    logic [1:N_SEL] old_s;
    logic [4:0]     exp;
    old_s     = rx_s;
    req_s     = 4'b0110;
    req_valid = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      req_valid = 1'b0;
      exp = expect_vec(2, 4'b0110, c);
      n_checks++;
      if (obs !== exp) $display("FAIL reset_mid cycle %0d: got %b, required %b", c, obs, exp);
      else n_pass++;
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (obs !== 5'b10000) $display("FAIL reset_mid_outputs: got %b, required 10000", obs);
    else n_pass++;
    rst = 1'b0;
    expect_idle(25, "reset_mid_after");
    n_checks++;
    if (rx_s !== old_s) $display("FAIL reset_mid_receiver_s: got %b, required %b", rx_s, old_s);
    else n_pass++;
  endtask

  task automatic test_hold_valid();
    logic [1:N_SEL] s1, s2;
    s1 = N_SEL'($urandom_range(0, 15));
    s2 = N_SEL'($urandom_range(0, 15));
    xfer(2, s1, 1'b1, 1'b1, s2, "hold_first");
    xfer(2, s2, 1'b0, 1'b0, 4'b0000, "hold_second");
    expect_idle(3, "hold_after");
  endtask

  task automatic test_clkdiv1();
    sel1 = 1'b1;
    prev_clk = 1'b0;
    xfer(1, 4'b0110, 1'b0, 1'b0, 4'b0000, "div1_0110");
    xfer(1, 4'b1001, 1'b1, 1'b0, 4'b0011, "div1_b2b_first");
    xfer(1, 4'b0011, 1'b0, 1'b0, 4'b0000, "div1_b2b_second");
    expect_idle(2, "div1_after");
    sel1 = 1'b0;
    prev_clk = 1'b0;
  endtask

  task automatic test_random();
    logic [1:N_SEL] s;
    for (int i = 0; i < 8; i++) begin
      s = N_SEL'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        sel1 = 1'b1;
        xfer(1, s, 1'b0, 1'b0, 4'b0000, "random_div1");
      end else begin
        sel1 = 1'b0;
        xfer(2, s, 1'b0, 1'b0, 4'b0000, "random_div2");
      end
      expect_idle(1, "random_after");
    end
    sel1 = 1'b0;
  endtask

`ifdef CPM_THERM_DECODE_EN
  // Reference: leading-ones count; a bubble is any deviation from the pure
  // thermometer code with that many leading ones.
  function automatic logic [EDGE_W:0] ref_decode(input logic [15:0] w);
    int          n;
    logic [15:0] thermo;
    n = 0;
    while (n < 16 && w[15 - n]) n++;
    thermo = ~(16'hFFFF >> n);
    return {EDGE_W'(n), (w !== thermo)};
  endfunction

  task automatic test_decode();
    logic [15:0]     table_w [4];
    logic [15:0]     w;
    logic [EDGE_W:0] exp;
    logic [EDGE_W:0] want [4];
    int              n;
    table_w[0] = 16'hFE00; want[0] = {5'd7, 1'b0};
    table_w[1] = 16'hFFFF; want[1] = {5'd16, 1'b0};
    table_w[2] = 16'h0000; want[2] = {5'd0, 1'b0};
    table_w[3] = 16'hE400; want[3] = {5'd3, 1'b1};
    for (int i = 0; i < 24; i++) begin
      if (i < 4) begin
        w   = table_w[i];
        exp = want[i];
      end else begin
        n = $urandom_range(0, 16);
        w = ~(16'hFFFF >> n);
        if ($urandom_range(0, 1) == 1) w = w ^ (16'h0001 << $urandom_range(0, 15));
        exp = ref_decode(w);
      end
      cpm_out = w;
      tick();
      n_checks++;
      if ({edge_pos2, bubble2} !== exp || {edge_pos1, bubble1} !== exp)
        $display("FAIL decode word %h: got %0d/%b and %0d/%b, required %0d/%b",
                 w, edge_pos2, bubble2, edge_pos1, bubble1, exp[EDGE_W:1], exp[0]);
      else
        n_pass++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_reset_mid();
    test_hold_valid();
    test_clkdiv1();
    test_random();
`ifdef CPM_THERM_DECODE_EN
    test_decode();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpm_sc_driver.md
# cpm_sc_driver

On-die controller that programs the Critical Path Monitor's 4-bit scan-chain select register (S[1:4]) from a parallel request. It generates the SC_DIN, SC_CLK and SC_LEN serial waveform consumed by the CPM scan-chain receiver. Optionally it also decodes the CPM's 16-bit thermometer edge word into an edge position. It sits between the PVT-sensor control logic and the CPM macro.

## Interface
- CLK_DIV, 4, SC_CLK half-period in CLK cycles; legal range 1..255
- CLK  in  1  system clock
- RST  in  1  synchronous reset, active-high
- CFG_S  in  [1:4]  requested select value, mapped bit-for-bit onto CPM S[1:4]
- CFG_VALID  in  1  request strobe
- CFG_READY  out  1  driver idle; a request is accepted when CFG_VALID & CFG_READY
- DONE  out  1  one-cycle pulse when the latch phase completes
- SC_DIN  out  1  scan serial data
- SC_CLK  out  1  scan clock
- SC_LEN  out  1  scan latch enable
- CPM_OUT  in  [1:16]  CPM edge word, already CLK-synchronous (CPM_THERM_DECODE_EN only)
- EDGE_POS  out  [4:0]  count of leading ones in CPM_OUT, range 0..16 (CPM_THERM_DECODE_EN only)
- BUBBLE  out  1  a 1 appears after the first 0 in CPM_OUT (CPM_THERM_DECODE_EN only)

## Operation
- All outputs are registered.
- Reset values: CFG_READY=1, DONE=0, SC_DIN=0, SC_CLK=0, SC_LEN=0, EDGE_POS=0, BUBBLE=0.
- FSM states and transitions:
  - IDLE → SHIFT_LO on accept.
  - SHIFT_LO → SHIFT_HI after CLK_DIV cycles.
  - SHIFT_HI → SHIFT_LO (next bit) after CLK_DIV cycles; after the 4th bit, SHIFT_HI → TAIL.
  - TAIL → LATCH after CLK_DIV cycles.
  - LATCH → IDLE after CLK_DIV cycles.
- CFG_S is captured into a shift register on accept. Later CFG_S changes are ignored.
- CFG_VALID is ignored outside IDLE.
- Bit order is S[4] first and S[1] last. The receiver shifts toward S[4], so after 4 rising edges its stage 1 holds S[1].
- Per state:
  - SHIFT_LO: SC_CLK=0; SC_DIN holds the current bit for the whole SHIFT_LO+SHIFT_HI pair (setup and hold of CLK_DIV cycles each).
  - SHIFT_HI: SC_CLK=1.
  - TAIL: SC_CLK=0, SC_DIN=0. This completes the final falling edge before latch.
  - LATCH: SC_LEN=1, SC_CLK=0.
- SC_CLK never toggles while SC_LEN=1, because the receiver re-latches on any SC_CLK edge while latch is high.
- CFG_READY = (state==IDLE). DONE is asserted on the first IDLE cycle after LATCH.
- Back-to-back: a request may be accepted in the same cycle DONE is high.
- Reset mid-operation: on the next edge all outputs return to reset values and the FSM enters IDLE. No SC_LEN pulse is issued, so the CPM keeps its previous S.
- Counters:
  - Phase counter is 8 bits and saturates-free: it compares against CLK_DIV-1.
  - Bit counter is 2 bits. Wrap from 3 is not used; the exit to TAIL is taken on bit==3.

## Timing
- Accept on edge 0.
- Bit k (k=0..3, value S[4-k]) is driven in cycles 2kD+1 .. 2kD+2D, where D=CLK_DIV.
- SC_CLK is high in cycles 2kD+D+1 .. 2kD+2D.
- TAIL occupies cycles 8D+1..9D. LATCH (SC_LEN=1) occupies cycles 9D+1..10D.
- DONE and CFG_READY are high in cycle 10D+1.
- Request-to-DONE latency is 10·CLK_DIV+1 cycles.
- Decoder: EDGE_POS and BUBBLE update every cycle, one cycle after CPM_OUT, independent of the FSM.

## Configuration
- CPM_THERM_DECODE_EN defined:
  - CPM_OUT, EDGE_POS and BUBBLE ports exist.
  - The thermometer decoder is instantiated.
- CPM_THERM_DECODE_EN undefined:
  - CPM_OUT, EDGE_POS and BUBBLE ports are absent.
  - No decoder logic is present.
  - The scan driver behaviour is unchanged.

## Structure
- Package cpm_pkg holds:
  - state enum sc_state_t {IDLE, SHIFT_LO, SHIFT_HI, TAIL, LATCH};
  - N_SEL=4;
  - N_TDC=16;
  - EDGE_W=5.
- Sub-module cpm_therm_decode (N_TDC-bit input, registered EDGE_POS/BUBBLE) is instantiated under the macro. The top holds only the FSM.

## Test plan
- CLK_DIV=2, CFG_S=4'b1010 (S[1]=1, S[2]=0, S[3]=1, S[4]=0) → SC_DIN at the SC_CLK rising edges in cycles 3, 7, 11, 15 equals 0, 1, 0, 1. SC_LEN is high in cycles 19–20. DONE fires in cycle 21. A behavioural receiver model latches S=1010.
- Back-to-back: 0001 then 1111, with the second CFG_VALID held from cycle 1 → the second request is accepted in cycle 21 and the model ends with S=1111.
- Reset pulse in cycle 10 of a transfer → SC_LEN never rises, outputs return to reset values, and the model's S is unchanged.
- CFG_VALID held high and CFG_S changed during a transfer → only the captured value is shifted, and exactly one accept occurs per DONE.
- Macro on, CPM_OUT: 16'hFE00 (ones in [1:7]) → EDGE_POS=7, BUBBLE=0; all ones → 16, 0; zero → 0, 0; ones in [1:3] and [6] → 3, 1.
- CLK_DIV=1 → 10-cycle transfer; SC_CLK is toggling every cycle during shift and no SC_CLK edge occurs while SC_LEN=1.
